// File: rtl/bht_branch_controller.sv
// Dynamic branch predictor for the 5-stage RV32I pipeline: a PC-indexed table of
// 2-bit saturating counters feeds IF, and EX trains it and sequences a one-cycle redirect/flush.
module bht_branch_controller #(
   parameter int         size     = 32,
   parameter int         ENTRIES  = 16,
   parameter int         IDX      = $clog2(ENTRIES),
   parameter logic [1:0] INIT_CTR = 2'b10,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [size-1:0]  instruction,
   input  logic [size-1:0]  if_pc,
   input  logic             isValid,
   output logic             Predicted_MPC,
   output logic             JALR,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_taken,
   input  logic             ex_predicted,
   input  logic [size-1:0]  ex_pc,
   input  logic [size-1:0]  ex_correct_pc,
   output logic             redirect_valid,
   output logic [size-1:0]  redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] mispredict_count
);

   typedef enum logic {
      ST_RUN,
      ST_RECOVER
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] ctr [ENTRIES];
   logic [4:0] opcode;
   logic       is_j;
   logic       is_b;
   logic       is_jalr;
   logic [IDX-1:0] if_idx;
   logic [IDX-1:0] ex_idx;
   logic       upd;
   logic       mp;
   logic       unused_bits;

   assign opcode  = instruction[6:2];
   assign is_j    = (opcode == 5'b11011);
   assign is_b    = (opcode == 5'b11000);
   assign is_jalr = (opcode == 5'b11001);
   assign if_idx  = if_pc[IDX+1:2];
   assign ex_idx  = ex_pc[IDX+1:2];

   assign Predicted_MPC = isValid & (is_j | (is_b & ctr[if_idx][1]));
   assign JALR          = isValid & is_jalr;

   // EX holds wrong-path work while flushing, so it neither trains nor mispredicts then.
   assign upd = ex_valid & ex_is_branch & ~flush;
   assign mp  = upd & (ex_taken != ex_predicted);

   assign unused_bits = ^{instruction[size-1:7], instruction[1:0],
                          if_pc[size-1:IDX+2], if_pc[1:0],
                          ex_pc[size-1:IDX+2], ex_pc[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      case (state)
         ST_RUN: begin
            if (mp) begin
               state_next = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            state_next     = ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         redirect_pc      <= '0;
         mispredict_count <= '0;
      end else if (mp) begin
         redirect_pc <= ex_correct_pc;
         if (mispredict_count != {CNT_W{1'b1}}) begin
            mispredict_count <= mispredict_count + CNT_W'(1);
         end
      end
   end

   // Lookups read the old value; a same-cycle update lands at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i] <= INIT_CTR;
         end
      end else if (upd) begin
         if (ex_taken && ctr[ex_idx] != 2'b11) begin
            ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
         end else if (!ex_taken && ctr[ex_idx] != 2'b00) begin
            ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_bht_branch_controller.sv
// Directed self-checking bench for bht_branch_controller; a narrow-counter
// second instance exercises mispredict-count saturation within a short run.
module tb_bht_branch_controller;

   localparam logic [31:0] BEQ_I  = 32'h00000063;
   localparam logic [31:0] JAL_I  = 32'h0000006F;
   localparam logic [31:0] JALR_I = 32'h00000067;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] if_pc;
   logic        isValid;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_taken;
   logic        ex_predicted;
   logic [31:0] ex_pc;
   logic [31:0] ex_correct_pc;

   logic        pred_mpc;
   logic        jalr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [15:0] mispredict_count;

   logic        s_pred_mpc;
   logic        s_jalr;
   logic        s_redirect_valid;
   logic [31:0] s_redirect_pc;
   logic        s_flush;
   logic [5:0]  s_mispredict_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bht_branch_controller dut (
      .clk(clk), .reset(reset), .instruction(instruction), .if_pc(if_pc),
      .isValid(isValid), .Predicted_MPC(pred_mpc), .JALR(jalr),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
      .ex_predicted(ex_predicted), .ex_pc(ex_pc), .ex_correct_pc(ex_correct_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .mispredict_count(mispredict_count)
   );

   bht_branch_controller #(.CNT_W(6)) dut_sat (
      .clk(clk), .reset(reset), .instruction(instruction), .if_pc(if_pc),
      .isValid(isValid), .Predicted_MPC(s_pred_mpc), .JALR(s_jalr),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
      .ex_predicted(ex_predicted), .ex_pc(ex_pc), .ex_correct_pc(ex_correct_pc),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush(s_flush),
      .mispredict_count(s_mispredict_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input logic valid);
      instruction = instr;
      if_pc       = pc;
      isValid     = valid;
      #1;
   endtask

   task automatic setEx(input logic valid, input logic taken, input logic predicted,
                        input logic [31:0] pc, input logic [31:0] correct_pc);
      ex_valid      = valid;
      ex_is_branch  = valid;
      ex_taken      = taken;
      ex_predicted  = predicted;
      ex_pc         = pc;
      ex_correct_pc = correct_pc;
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(32'h0, 32'h0, 1'b0);
      stepClk();
      stepClk();
      reset = 1'b0;
      #1;
      checkOutput("rst_pred", {31'b0, pred_mpc}, 32'd0);
      checkOutput("rst_jalr", {31'b0, jalr}, 32'd0);
      checkOutput("rst_rv", {31'b0, redirect_valid}, 32'd0);
      checkOutput("rst_flush", {31'b0, flush}, 32'd0);
      checkOutput("rst_count", {16'b0, mispredict_count}, 32'd0);
      checkOutput("rst_rpc", redirect_pc, 32'd0);

      applyStimulus(BEQ_I, 32'h40, 1'b1);
      checkOutput("beq_init_pred", {31'b0, pred_mpc}, 32'd1);
      applyStimulus(JAL_I, 32'h40, 1'b1);
      checkOutput("jal_pred", {31'b0, pred_mpc}, 32'd1);
      checkOutput("jal_jalr", {31'b0, jalr}, 32'd0);
      applyStimulus(JALR_I, 32'h40, 1'b1);
      checkOutput("jalr_jalr", {31'b0, jalr}, 32'd1);
      checkOutput("jalr_pred", {31'b0, pred_mpc}, 32'd0);
      applyStimulus(BEQ_I, 32'h40, 1'b0);
      checkOutput("inv_pred", {31'b0, pred_mpc}, 32'd0);
      applyStimulus(JALR_I, 32'h40, 1'b0);
      checkOutput("inv_jalr", {31'b0, jalr}, 32'd0);

      // Train 0x40 down: 10 -> 01 (mispredict) -> 00 -> 00
      setEx(1'b1, 1'b0, 1'b1, 32'h40, 32'h44);
      stepClk();
      setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("train_rv", {31'b0, redirect_valid}, 32'd1);
      checkOutput("train_rpc", redirect_pc, 32'h44);
      stepClk();
      setEx(1'b1, 1'b0, 1'b0, 32'h40, 32'h44);
      stepClk();
      stepClk();
      setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(BEQ_I, 32'h40, 1'b1);
      checkOutput("trained_pred", {31'b0, pred_mpc}, 32'd0);
      checkOutput("train_count", {16'b0, mispredict_count}, 32'd1);
      checkOutput("train_flush", {31'b0, flush}, 32'd0);

      // Mispredict at cycle N, wrong-path mispredict presented during RECOVER
      setEx(1'b1, 1'b1, 1'b0, 32'h80, 32'h200);
      #1;
      checkOutput("mpN_rv", {31'b0, redirect_valid}, 32'd0);
      stepClk();
      setEx(1'b1, 1'b0, 1'b1, 32'h48, 32'h4C);
      #1;
      checkOutput("mpN1_rv", {31'b0, redirect_valid}, 32'd1);
      checkOutput("mpN1_flush", {31'b0, flush}, 32'd1);
      checkOutput("mpN1_rpc", redirect_pc, 32'h200);
      stepClk();
      setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("mpN2_rv", {31'b0, redirect_valid}, 32'd0);
      checkOutput("mpN2_flush", {31'b0, flush}, 32'd0);
      checkOutput("mpN2_count", {16'b0, mispredict_count}, 32'd2);
      checkOutput("mpN2_rpc_hold", redirect_pc, 32'h200);
      applyStimulus(BEQ_I, 32'h48, 1'b1);
      checkOutput("rec_no_train", {31'b0, pred_mpc}, 32'd1);
      applyStimulus(BEQ_I, 32'h80, 1'b1);
      checkOutput("idx0_weak", {31'b0, pred_mpc}, 32'd0);

      // Correctly predicted taken update at 0x80 (alias of 0x40): 01 -> 10
      setEx(1'b1, 1'b1, 1'b1, 32'h80, 32'h300);
      stepClk();
      setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(BEQ_I, 32'h40, 1'b1);
      checkOutput("inc_pred", {31'b0, pred_mpc}, 32'd1);
      checkOutput("inc_flush", {31'b0, flush}, 32'd0);
      checkOutput("inc_count", {16'b0, mispredict_count}, 32'd2);

      // Same-cycle update and lookup at aliased index 5
      applyStimulus(BEQ_I, 32'h54, 1'b1);
      setEx(1'b1, 1'b0, 1'b1, 32'h14, 32'h18);
      #1;
      checkOutput("rbw_same", {31'b0, pred_mpc}, 32'd1);
      stepClk();
      setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("rbw_next", {31'b0, pred_mpc}, 32'd0);
      checkOutput("rbw_rpc", redirect_pc, 32'h18);
      stepClk();

      // Reset while in RECOVER aborts the redirect and restores the table
      setEx(1'b1, 1'b1, 1'b0, 32'h40, 32'h300);
      stepClk();
      setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      #1;
      checkOutput("pre_rst_flush", {31'b0, flush}, 32'd1);
      stepClk();
      reset = 1'b0;
      applyStimulus(BEQ_I, 32'h54, 1'b1);
      checkOutput("rec_rst_flush", {31'b0, flush}, 32'd0);
      checkOutput("rec_rst_rv", {31'b0, redirect_valid}, 32'd0);
      checkOutput("rec_rst_count", {16'b0, mispredict_count}, 32'd0);
      checkOutput("rec_rst_rpc", redirect_pc, 32'd0);
      checkOutput("rec_rst_ctr", {31'b0, pred_mpc}, 32'd1);

      // 70 back-to-back mispredicts: narrow instance saturates at 63
      for (int i = 0; i < 70; i++) begin
         setEx(1'b1, 1'b1, 1'b0, 32'h100, 32'h400);
         stepClk();
         setEx(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         stepClk();
      end
      checkOutput("count_70", {16'b0, mispredict_count}, 32'd70);
      checkOutput("sat_count", {26'b0, s_mispredict_count}, 32'd63);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
